// File: rtl/escritura_de_parametros_pkg.sv
// Shared constants for the RTC parameter writer: register map, commands,
// bus phase timing and FSM state encodings.
package escritura_de_parametros_pkg;

  localparam logic [7:0] ADDR_FMT   = 8'h00;
  localparam logic [7:0] ADDR_CTRL  = 8'h02;
  localparam logic [7:0] ADDR_CFG   = 8'h10;
  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  localparam logic [7:0] ADDR_TSEC  = 8'h41;
  localparam logic [7:0] ADDR_TMIN  = 8'h42;
  localparam logic [7:0] ADDR_THOUR = 8'h43;

  localparam logic [7:0] CMD_TIME   = 8'hF1;
  localparam logic [7:0] CMD_TIMER  = 8'hF2;

  localparam logic [7:0] CTRL_HOLD  = 8'h10;
  localparam logic [7:0] CTRL_RUN   = 8'h00;
  localparam logic [7:0] CFG_INIT   = 8'hD2;
  localparam logic [7:0] FMT_12H    = 8'h10;
  localparam logic [7:0] FMT_24H    = 8'h00;

  // Per-transaction cycle positions: addr 0..1, gap 2, data 3..4, gap 5
  localparam logic [2:0] ADDR_CYC   = 3'd2;
  localparam logic [2:0] DATA_FIRST = 3'd3;
  localparam logic [2:0] DATA_END   = 3'd5;
  localparam logic [2:0] WRITE_LAST = 3'd5;
  localparam logic [2:0] CMD_LAST   = 3'd2;

  // Step indices within a parameter write (date/time 0..6, timer 7..10)
  localparam logic [3:0] INIT_STEPS     = 4'd4;
  localparam logic [3:0] TIME_CMD_STEP  = 4'd6;
  localparam logic [3:0] TIME_STEPS     = 4'd7;
  localparam logic [3:0] TIMER_CMD_STEP = 4'd10;
  localparam logic [3:0] ALL_STEPS      = 4'd11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INIT     = 3'd1;
  localparam logic [2:0] ST_WR_TIME  = 3'd2;
  localparam logic [2:0] ST_WR_TIMER = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  typedef struct packed {
    logic       cmd_only;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_tx_t;

  function automatic bus_tx_t wr_tx(input logic [7:0] addr, input logic [7:0] data);
    return '{cmd_only: 1'b0, addr: addr, data: data};
  endfunction

  function automatic bus_tx_t cmd_tx(input logic [7:0] cmd);
    return '{cmd_only: 1'b1, addr: cmd, data: 8'h00};
  endfunction

endpackage

// File: rtl/escritura_de_parametros_rtc_bus_write.sv
// One RTC bus transaction: register write (6 cycles) or command (3 cycles).
// A start on the final cycle of a transaction chains the next one with no gap.
module rtc_bus_write
  import escritura_de_parametros_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cmd_only,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       AD,
  output logic       CS,
  output logic       WR,
  output logic [7:0] Dato
);

  logic [2:0] cnt;
  logic       cmd_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      cmd_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      cmd_q  <= cmd_only;
      addr_q <= addr;
      data_q <= data;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign done = busy && (cnt == (cmd_q ? CMD_LAST : WRITE_LAST));

  always_comb begin
    AD   = 1'b1;
    CS   = 1'b1;
    WR   = 1'b1;
    Dato = 8'h00;
    if (busy && (cnt < ADDR_CYC)) begin
      AD   = 1'b0;
      CS   = 1'b0;
      WR   = 1'b0;
      Dato = addr_q;
    end else if (busy && !cmd_q && (cnt >= DATA_FIRST) && (cnt < DATA_END)) begin
      CS   = 1'b0;
      WR   = 1'b0;
      Dato = data_q;
    end
  end

endmodule

// File: rtl/escritura_de_parametros.sv
// RTC parameter writer: one-time init sequence, then date/time and/or timer
// block writes on request, with done pulses for each.
//
// state       | meaning
// ST_IDLE     | bus idle, waiting for EN and a request (or pending init)
// ST_INIT     | four init register writes
// ST_WR_TIME  | date/time registers 0x21..0x26 then command 0xF1
// ST_WR_TIMER | timer registers 0x41..0x43 then command 0xF2
// ST_DONE     | one-cycle Listo_es pulse, disarm
module escritura_de_parametros
  import escritura_de_parametros_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic       Ld_1,
  input  logic       Ld_2,
  input  logic       up,
  input  logic       down,
  input  logic       forma,
  input  logic [7:0] s,
  input  logic [7:0] m,
  input  logic [7:0] h,
  input  logic [7:0] d,
  input  logic [7:0] me,
  input  logic [7:0] a,
  input  logic [7:0] st,
  input  logic [7:0] mt,
  input  logic [7:0] ht,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic [7:0] Dato,
  output logic       Listo_limpia,
  output logic       Listo_es
);

  logic [2:0]      state;
  logic [3:0]      step;
  logic            init_pend;
  logic            armed;
  logic            full_q;
  logic            forma_q;
  logic [5:0][7:0] time_q;
  logic [2:0][7:0] timer_q;
  logic            listo_limpia_q;

  logic       any_req;
  logic       active;
  logic [3:0] seq_end;
  logic [1:0] timer_idx;
  logic       bw_start;
  logic       bw_busy;
  logic       bw_done;
  logic       seq_last;
  bus_tx_t    tx;

  assign any_req = Ld_1 || Ld_2 || up || down;
  assign active  = (state == ST_INIT) || (state == ST_WR_TIME) || (state == ST_WR_TIMER);
  assign seq_end = (state == ST_INIT) ? INIT_STEPS :
                   ((state == ST_WR_TIME) && !full_q) ? TIME_STEPS : ALL_STEPS;
  // Steps 7..9 map to timer slots 0..2 through the low two bits
  assign timer_idx = step[1:0] + 2'd1;
  assign bw_start  = active && (step < seq_end) && (!bw_busy || bw_done);
  assign seq_last  = active && (step == seq_end) && bw_done;

  always_comb begin
    tx = '0;
    case (state)
      ST_INIT: begin
        case (step)
          4'd0:    tx = wr_tx(ADDR_CTRL, CTRL_HOLD);
          4'd1:    tx = wr_tx(ADDR_CTRL, CTRL_RUN);
          4'd2:    tx = wr_tx(ADDR_CFG, CFG_INIT);
          default: tx = wr_tx(ADDR_FMT, forma_q ? FMT_12H : FMT_24H);
        endcase
      end
      ST_WR_TIME, ST_WR_TIMER: begin
        if (step < TIME_CMD_STEP)
          tx = wr_tx(ADDR_SEC + {4'd0, step}, time_q[step[2:0]]);
        else if (step == TIME_CMD_STEP)
          tx = cmd_tx(CMD_TIME);
        else if (step < TIMER_CMD_STEP)
          tx = wr_tx(ADDR_TSEC + {6'd0, timer_idx}, timer_q[timer_idx]);
        else
          tx = cmd_tx(CMD_TIMER);
      end
      default: tx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      step           <= '0;
      init_pend      <= 1'b1;
      armed          <= 1'b1;
      full_q         <= 1'b0;
      forma_q        <= 1'b0;
      time_q         <= '0;
      timer_q        <= '0;
      listo_limpia_q <= 1'b0;
    end else begin
      listo_limpia_q <= 1'b0;
      if (bw_start) step <= step + 4'd1;
      case (state)
        ST_IDLE: begin
          if (!any_req) armed <= 1'b1;
          if (EN && init_pend) begin
            state   <= ST_INIT;
            step    <= '0;
            forma_q <= forma;
          end else if (EN && armed && any_req) begin
            time_q  <= {a, me, d, h, m, s};
            timer_q <= {ht, mt, st};
            forma_q <= forma;
            full_q  <= !Ld_1 && !Ld_2;
            if (Ld_2 && !Ld_1) begin
              state <= ST_WR_TIMER;
              step  <= TIME_STEPS;
            end else begin
              state <= ST_WR_TIME;
              step  <= '0;
            end
          end
        end
        ST_INIT: begin
          if (seq_last) begin
            state          <= ST_IDLE;
            init_pend      <= 1'b0;
            listo_limpia_q <= 1'b1;
          end
        end
        ST_WR_TIME: begin
          if (seq_last) state <= ST_DONE;
          else if (bw_start && (step == TIME_STEPS)) state <= ST_WR_TIMER;
        end
        ST_WR_TIMER: begin
          if (seq_last) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          armed <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rtc_bus_write u_bus (
    .clk      (clk),
    .rst      (rst),
    .start    (bw_start),
    .cmd_only (tx.cmd_only),
    .addr     (tx.addr),
    .data     (tx.data),
    .busy     (bw_busy),
    .done     (bw_done),
    .AD       (AD),
    .CS       (CS),
    .WR       (WR),
    .Dato     (Dato)
  );

  assign RD           = 1'b1;
  assign Listo_limpia = listo_limpia_q;
  assign Listo_es     = (state == ST_DONE);

endmodule

// File: tb/tb_escritura_de_parametros.sv
// Bench for escritura_de_parametros: bus monitor decodes RTC transactions and
// compares them against a queue of expected writes/commands.
module tb_escritura_de_parametros;

  typedef struct packed {
    logic       c;
    logic [7:0] a;
    logic [7:0] d;
  } tx_t;

  logic clk = 1'b0;
  logic rst, EN, Ld_1, Ld_2, up, down, forma;
  logic [7:0] s, m, h, d, me, a, st, mt, ht;
  logic AD, CS, RD, WR, Listo_limpia, Listo_es;
  logic [7:0] Dato;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int es_cnt = 0, lim_cnt = 0, act_cnt = 0, idle_viol = 0, proto_err = 0;
  tx_t sb[$];

  always #5 clk = ~clk;

  escritura_de_parametros dut (
    .clk(clk), .rst(rst), .EN(EN), .Ld_1(Ld_1), .Ld_2(Ld_2), .up(up), .down(down),
    .forma(forma), .s(s), .m(m), .h(h), .d(d), .me(me), .a(a), .st(st), .mt(mt), .ht(ht),
    .AD(AD), .CS(CS), .RD(RD), .WR(WR), .Dato(Dato),
    .Listo_limpia(Listo_limpia), .Listo_es(Listo_es)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input logic [7:0] ad, input logic [7:0] dt);
    sb.push_back({1'b0, ad, dt});
  endtask

  task automatic push_cmd(input logic [7:0] c);
    sb.push_back({1'b1, c, 8'h00});
  endtask

  task automatic push_init(input logic f);
    push_wr(8'h02, 8'h10);
    push_wr(8'h02, 8'h00);
    push_wr(8'h10, 8'hD2);
    push_wr(8'h00, f ? 8'h10 : 8'h00);
  endtask

  task automatic push_time();
    push_wr(8'h21, s);
    push_wr(8'h22, m);
    push_wr(8'h23, h);
    push_wr(8'h24, d);
    push_wr(8'h25, me);
    push_wr(8'h26, a);
    push_cmd(8'hF1);
  endtask

  task automatic push_timer();
    push_wr(8'h41, st);
    push_wr(8'h42, mt);
    push_wr(8'h43, ht);
    push_cmd(8'hF2);
  endtask

  task automatic emit_tx(input logic c, input logic [7:0] ad, input logic [7:0] dt);
    tx_t e;
    check_val("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("bus_tx", {15'd0, c, ad, dt}, {15'd0, e});
    end
  endtask

  task automatic cyc_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // ph: 0 wait addr, 1 in addr phase, 2 addr done + gap, 3 in data phase
  task automatic bus_monitor();
    int ph;
    int len;
    logic [7:0] addr_v, data_v;
    ph = 0; len = 0; addr_v = '0; data_v = '0;
    forever begin
      @(negedge clk);
      if (Listo_es) es_cnt++;
      if (Listo_limpia) lim_cnt++;
      if (!CS) act_cnt++;
      if (RD !== 1'b1 || (CS && (AD !== 1'b1 || WR !== 1'b1 || Dato !== 8'h00)) || (!CS && WR !== 1'b0))
        idle_viol++;
      if (rst) ph = 0;
      else begin
        case (ph)
          0: begin
            if (!CS && !AD) begin addr_v = Dato; len = 1; ph = 1; end
            else if (!CS) proto_err++;
          end
          1: begin
            if (!CS && !AD) begin len++; if (Dato !== addr_v) proto_err++; end
            else if (CS) begin if (len != 2) proto_err++; ph = 2; end
            else begin proto_err++; ph = 0; end
          end
          2: begin
            if (!CS && AD) begin data_v = Dato; len = 1; ph = 3; end
            else begin
              emit_tx(1'b1, addr_v, 8'h00);
              if (!CS) begin addr_v = Dato; len = 1; ph = 1; end
              else ph = 0;
            end
          end
          default: begin
            if (!CS && AD) begin len++; if (Dato !== data_v) proto_err++; end
            else if (CS) begin
              if (len != 2) proto_err++;
              emit_tx(1'b0, addr_v, data_v);
              ph = 0;
            end else begin proto_err++; ph = 0; end
          end
        endcase
      end
    end
  endtask

  // which: 0 = bus activity, 1 = Listo_limpia, 2 = Listo_es
  task automatic wait_for(input int which, input int max_cyc, input string tag, output int at);
    logic hit;
    hit = 1'b0;
    at = -1;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = !CS;
        1: hit = Listo_limpia;
        default: hit = Listo_es;
      endcase
      if (hit) at = cyc;
    end
    check_val(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, t1, t2, a0, e0, l0;
    rst = 1'b1; EN = 1'b0; Ld_1 = 1'b0; Ld_2 = 1'b0; up = 1'b0; down = 1'b0; forma = 1'b0;
    s = 8'h23; m = 8'h45; h = 8'h12; d = 8'h31; me = 8'h12; a = 8'h16;
    st = 8'h59; mt = 8'h59; ht = 8'h21;
    fork
      bus_monitor();
      cyc_counter();
    join_none

    repeat (3) @(negedge clk);
    check_val("rst_bus", {20'd0, AD, CS, RD, WR, Dato}, 32'hF00);
    check_val("rst_listo", {30'd0, Listo_es, Listo_limpia}, 32'd0);
    rst = 1'b0;

    // EN low: requests ignored, init stays pending
    up = 1'b1; Ld_1 = 1'b1;
    settle();
    a0 = act_cnt; e0 = es_cnt; l0 = lim_cnt;
    repeat (20) @(negedge clk);
    settle();
    check_val("en0_bus", act_cnt - a0, 0);
    check_val("en0_listo", (es_cnt - e0) + (lim_cnt - l0), 0);

    // init then full write
    @(negedge clk);
    Ld_1 = 1'b0;
    push_init(1'b0); push_time(); push_timer();
    e0 = es_cnt; l0 = lim_cnt;
    EN = 1'b1;
    wait_for(1, 100, "init_done", t0);
    wait_for(0, 10, "full_start", t1);
    wait_for(2, 120, "full_done", t2);
    check_val("full_len", t2 - t1, 60);
    settle();
    check_val("full_sb_empty", sb.size(), 0);
    check_val("full_limpia_cnt", lim_cnt - l0, 1);
    check_val("full_es_cnt", es_cnt - e0, 1);

    // held request does not retrigger; release and reassert does once
    a0 = act_cnt; e0 = es_cnt;
    repeat (30) @(negedge clk);
    settle();
    check_val("hold_bus", act_cnt - a0, 0);
    check_val("hold_es", es_cnt - e0, 0);
    @(negedge clk);
    up = 1'b0;
    s = 8'h01; m = 8'h02; h = 8'h03; d = 8'h04; me = 8'h05; a = 8'h06;
    st = 8'h07; mt = 8'h08; ht = 8'h09;
    repeat (2) @(negedge clk);
    push_time(); push_timer();
    up = 1'b1;
    wait_for(2, 120, "rearm_done", t2);
    @(negedge clk);
    up = 1'b0;
    settle();
    check_val("rearm_es_cnt", es_cnt - e0, 1);
    check_val("rearm_sb_empty", sb.size(), 0);

    // Ld_1 and Ld_2 together: date/time block only
    repeat (2) @(negedge clk);
    s = 8'h10; m = 8'h20; h = 8'h08; d = 8'h15; me = 8'h07; a = 8'h24;
    push_time();
    Ld_1 = 1'b1; Ld_2 = 1'b1;
    wait_for(0, 10, "both_start", t1);
    wait_for(2, 80, "both_done", t2);
    check_val("both_len", t2 - t1, 39);
    settle();
    a0 = act_cnt;
    repeat (20) @(negedge clk);
    settle();
    check_val("both_hold_bus", act_cnt - a0, 0);
    check_val("both_sb_empty", sb.size(), 0);
    @(negedge clk);
    Ld_1 = 1'b0; Ld_2 = 1'b0;
    repeat (2) @(negedge clk);
    st = 8'h30; mt = 8'h15; ht = 8'h02;
    push_timer();
    Ld_2 = 1'b1;
    wait_for(0, 10, "timer_start", t1);
    wait_for(2, 60, "timer_done", t2);
    check_val("timer_len", t2 - t1, 21);
    @(negedge clk);
    Ld_2 = 1'b0;
    settle();
    check_val("timer_sb_empty", sb.size(), 0);

    // inputs captured at accept: later change of s is not written
    repeat (2) @(negedge clk);
    s = 8'h23;
    push_time();
    Ld_1 = 1'b1;
    wait_for(0, 10, "capt_start", t1);
    repeat (5) @(negedge clk);
    s = 8'h45; Ld_1 = 1'b0;
    wait_for(2, 80, "capt_done", t2);
    check_val("capt_len", t2 - t1, 39);
    settle();
    check_val("capt_sb_empty", sb.size(), 0);

    // reset in the middle of a timer write
    repeat (2) @(negedge clk);
    push_timer();
    Ld_2 = 1'b1;
    wait_for(0, 10, "abort_start", t1);
    repeat (8) @(negedge clk);
    Ld_2 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    check_val("abort_pre_cs", {31'd0, CS}, 32'd0);
    settle();
    check_val("abort_bus_idle", {20'd0, AD, CS, RD, WR, Dato}, 32'hF00);
    EN = 1'b0; forma = 1'b1; Ld_2 = 1'b1; up = 1'b1;
    a0 = act_cnt; e0 = es_cnt; l0 = lim_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    settle();
    check_val("abort_en0_bus", act_cnt - a0, 0);
    check_val("abort_no_es", es_cnt - e0, 0);
    check_val("abort_no_limpia", lim_cnt - l0, 0);

    // init reruns, now with 12 h format
    @(negedge clk);
    Ld_2 = 1'b0; up = 1'b0;
    push_init(1'b1);
    EN = 1'b1;
    wait_for(1, 60, "reinit_done", t0);
    settle();
    check_val("reinit_sb_empty", sb.size(), 0);
    check_val("reinit_limpia_cnt", lim_cnt - l0, 1);

    repeat (5) @(negedge clk);
    settle();
    check_val("final_sb_empty", sb.size(), 0);
    check_val("bus_protocol", proto_err, 0);
    check_val("bus_idle_rules", idle_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/escritura_de_parametros.md
ESCRITURA_DE_PARAMETROS -- requirements
Module: escritura_de_parametros

Interface
REQ-001 SHALL have ports: clk, input, 1, system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports: EN, input, 1, block enable, sampled only in IDLE.
REQ-004 SHALL have ports: Ld_1 / Ld_2 / up / down, input, 1 each, write requests: date/time, timer, full write.
REQ-005 SHALL have ports: forma, input, 1, hour format (1 = 12 h, 0 = 24 h).
REQ-006 SHALL have ports: s, m, h, d, me, a, input, 8 each, BCD seconds, minutes, hours, day, month, year.
REQ-007 SHALL have ports: st, mt, ht, input, 8 each, BCD timer seconds, minutes, hours.
REQ-008 SHALL have ports: AD, CS, RD, WR, output, 1 each, RTC bus strobes; CS/RD/WR active-low; AD=0 address phase, AD=1 data phase.
REQ-009 SHALL have ports: Dato, output, 8, multiplexed address/data bus value.
REQ-010 SHALL have ports: Listo_limpia / Listo_es, output, 1 each, one-cycle done pulses for init and parameter-write sequences.
REQ-011 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-012 SHALL hold bus idle (AD=1, CS=1, RD=1, WR=1, Dato=0x00) whenever no transaction is active; RD SHALL be 1 at all times.
REQ-013 SHALL run each register write as 6 cycles: 2 cycles AD=0,CS=0,WR=0,Dato=addr; 1 cycle idle; 2 cycles AD=1,CS=0,WR=0,Dato=data; 1 cycle idle.
REQ-014 SHALL run a command transaction as 3 cycles: 2 cycles AD=0,CS=0,WR=0,Dato=cmd; 1 cycle idle.
REQ-015 SHALL use states IDLE, INIT, WR_TIME, WR_TIMER, DONE.
REQ-016 SHALL, after reset with an init still pending, go from IDLE to INIT on the first cycle EN=1.
REQ-017 INIT SHALL write 0x02<-0x10, 0x02<-0x00, 0x10<-0xD2, 0x00<-(forma?0x10:0x00) (24 cycles), then pulse Listo_limpia for 1 cycle, clear the init-pending flag, and return to IDLE.
REQ-018 SHALL, in IDLE with EN=1, no pending init, and armed, accept requests with priority Ld_1 > Ld_2 > (up|down).
REQ-019 Ld_1 SHALL trigger WR_TIME: 0x21<-s, 0x22<-m, 0x23<-h, 0x24<-d, 0x25<-me, 0x26<-a, then command 0xF1 (39 cycles).
REQ-020 Ld_2 SHALL trigger WR_TIMER: 0x41<-st, 0x42<-mt, 0x43<-ht, then command 0xF2 (21 cycles).
REQ-021 up|down SHALL trigger WR_TIME followed immediately by WR_TIMER (60 cycles).
REQ-022 SHALL capture all parameter inputs into registers on the cycle the request is accepted; later input changes SHALL NOT affect that sequence.
REQ-023 SHALL pulse Listo_es for 1 cycle (DONE state) after the last transaction of any parameter write, then return to IDLE.
REQ-024 SHALL disarm after a completed sequence; it rearms only after one IDLE cycle with Ld_1, Ld_2, up, down all 0.
REQ-025 SHALL ignore EN and all requests while a sequence is running; a running sequence always completes.

Reset
REQ-026 SHALL, on rst=1, force IDLE, bus idle values, Listo_es=0, Listo_limpia=0, captured registers=0x00, set init-pending=1, and set armed=1.
REQ-027 SHALL abort a sequence on rst asserted mid-sequence, with the bus idle on the next cycle.

Structure
REQ-028 SHALL place register addresses (0x00, 0x02, 0x10, 0x21–0x26, 0x41–0x43), commands 0xF1/0xF2, the init value 0xD2, phase lengths, and the state enum in a shared package.
REQ-029 SHALL place the single-transaction bus timing in a sub-module rtc_bus_write, with inputs start, cmd_only, addr, data, and outputs busy, done, AD, CS, WR, Dato.

Verification
REQ-030 Reset, then EN=1, up=1, forma=0: INIT writes are 0x02/0x10, 0x02/0x00, 0x10/0xD2, 0x00/0x00; Listo_limpia pulses; the full write follows with s=0x23 at 0x21 … a=0x16 at 0x26, command 0xF1, st=0x59 at 0x41, mt=0x59 at 0x42, ht=0x21 at 0x43, command 0xF2; Listo_es pulses once.
REQ-031 Holding up=1 after REQ-030 SHALL produce no second write; pulsing up 0 then 1 SHALL produce exactly one more write.
REQ-032 Ld_1=1 and Ld_2=1 together: only the date/time block plus 0xF1 runs (39 cycles); a second request of either kind needs a rearm.
REQ-033 EN=0 with requests active: the bus stays idle and no Listo pulse occurs; with forma=1, INIT writes 0x00<-0x10.
REQ-034 Change s from 0x23 to 0x45 mid-WR_TIME: 0x21 is still written 0x23.
REQ-035 Assert rst during WR_TIMER: the bus is idle next cycle, no Listo_es pulse occurs, and INIT reruns when EN=1.
